// File: rtl/sha256_cfu_pkg.sv
// Shared types and constants for the SHA-256 CFU sequencer.
// The optional core watchdog is enabled with the SHA256_CFU_WATCHDOG_EN macro.
package sha256_cfu_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 8;

  typedef enum logic [2:0] {
    OP_INIT     = 3'd0,
    OP_WR_STATE = 3'd1,
    OP_RUN      = 3'd2,
    OP_RD_STATE = 3'd3,
    OP_STATUS   = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_ACCUM     = 3'd4,
    ST_RESP      = 3'd5
  } fsm_e;

  localparam logic [31:0] SHA256_IV [NUM_WORDS] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] WDOG_ERR_CODE = 32'hDEAD0001;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_RDY_BIT  = 1;
  localparam int STATUS_CNT_LSB  = 16;

  function automatic logic [255:0] iv_state();
    logic [255:0] s;
    s = 256'd0;
    for (int i = 0; i < NUM_WORDS; i++) s[WORD_W*i +: WORD_W] = SHA256_IV[i];
    return s;
  endfunction

  function automatic logic [31:0] status_word(input logic [15:0] cnt, input logic rdy,
                                              input logic busy);
    logic [31:0] w;
    w = 32'd0;
    w[STATUS_CNT_LSB +: 16] = cnt;
    w[STATUS_RDY_BIT]       = rdy;
    w[STATUS_BUSY_BIT]      = busy;
    return w;
  endfunction

endpackage

// File: rtl/sha256_feedforward_add.sv
// Eight-lane 32-bit modular adder used for the SHA-256 feed-forward step.
module sha256_feedforward_add
  import sha256_cfu_pkg::*;
(
  input  logic [255:0] state_s,
  input  logic [255:0] final_s,
  output logic [255:0] sum_s
);

  // Lane-wise add, carries never cross word boundaries
  always_comb begin
    sum_s = 256'd0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      sum_s[WORD_W*i +: WORD_W] = state_s[WORD_W*i +: WORD_W] + final_s[WORD_W*i +: WORD_W];
    end
  end

endmodule

// File: rtl/sha256_cfu_sequencer.sv
// Command sequencer between the CFU port and the SHA-256 compression core.
// Define SHA256_CFU_WATCHDOG_EN to build in the core run watchdog.
module sha256_cfu_sequencer
  import sha256_cfu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 512,
  parameter int BASE_W         = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [2:0]        req_idx,
  input  logic [31:0]       req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_err,
  output logic              core_en,
  output logic              core_rst_n,
  output logic [BASE_W-1:0] core_base,
  output logic [255:0]      core_init,
  input  logic              core_rdy,
  input  logic [255:0]      core_final
);

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  fsm_e              fsm_r;
  logic [255:0]      state_r;
  logic [255:0]      final_r;
  logic [255:0]      sum_s;
  logic [15:0]       blk_cnt_r;
  logic              busy_cnt_r;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [31:0]       rsp_data_r;
  logic              rsp_err_r;
  logic              core_en_r;
  logic              core_rst_n_r;
  logic [BASE_W-1:0] core_base_r;
`ifdef SHA256_CFU_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0]   wd_cnt_r;
`endif

  sha256_feedforward_add u_ff_add (
    .state_s (state_r),
    .final_s (final_r),
    .sum_s   (sum_s)
  );

  assign req_ready  = req_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_err    = rsp_err_r;
  assign core_en    = core_en_r;
  assign core_rst_n = core_rst_n_r;
  assign core_base  = core_base_r;
  assign core_init  = state_r;

  // Command FSM with chaining state and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r        <= ST_IDLE;
      state_r      <= iv_state();
      final_r      <= 256'd0;
      blk_cnt_r    <= 16'd0;
      busy_cnt_r   <= 1'b0;
      req_ready_r  <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= 32'd0;
      rsp_err_r    <= 1'b0;
      core_en_r    <= 1'b0;
      core_rst_n_r <= 1'b0;
      core_base_r  <= {BASE_W{1'b0}};
`ifdef SHA256_CFU_WATCHDOG_EN
      wd_cnt_r     <= {WD_W{1'b0}};
`endif
    end else begin
      core_rst_n_r <= 1'b1;
      core_en_r    <= 1'b0;
      case (fsm_r)
        ST_IDLE: begin
          if (req_valid && req_ready_r) begin
            req_ready_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= 32'd0;
            rsp_valid_r <= 1'b1;
            fsm_r       <= ST_RESP;
            case (req_op)
              OP_INIT: begin
                state_r   <= iv_state();
                blk_cnt_r <= 16'd0;
              end
              OP_WR_STATE: begin
                state_r[{req_idx, 5'd0} +: WORD_W] <= req_data;
                rsp_data_r <= req_data;
              end
              OP_RD_STATE: rsp_data_r <= state_r[{req_idx, 5'd0} +: WORD_W];
              OP_STATUS:   rsp_data_r <= status_word(blk_cnt_r, core_rdy, fsm_r != ST_IDLE);
              OP_RUN: begin
                core_base_r <= req_data[BASE_W-1:0];
                core_en_r   <= 1'b1;
                rsp_valid_r <= 1'b0;
                fsm_r       <= ST_LAUNCH;
              end
              default: rsp_err_r <= 1'b1;
            endcase
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          busy_cnt_r <= 1'b0;
          fsm_r      <= ST_WAIT_BUSY;
        end
        // A core that never drops rdy is reported rather than waited on
        ST_WAIT_BUSY: begin
          if (!core_rdy) begin
            fsm_r <= ST_WAIT_DONE;
`ifdef SHA256_CFU_WATCHDOG_EN
            wd_cnt_r <= {WD_W{1'b0}};
`endif
          end else if (busy_cnt_r) begin
            rsp_err_r   <= 1'b1;
            rsp_data_r  <= 32'd0;
            rsp_valid_r <= 1'b1;
            fsm_r       <= ST_RESP;
          end else begin
            busy_cnt_r <= 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (core_rdy) begin
            final_r <= core_final;
            fsm_r   <= ST_ACCUM;
`ifdef SHA256_CFU_WATCHDOG_EN
          end else if (wd_cnt_r == WD_W'(TIMEOUT_CYCLES - 1)) begin
            core_rst_n_r <= 1'b0;
            rsp_err_r    <= 1'b1;
            rsp_data_r   <= WDOG_ERR_CODE;
            rsp_valid_r  <= 1'b1;
            fsm_r        <= ST_RESP;
          end else begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
`else
          end else begin
            fsm_r <= ST_WAIT_DONE;
`endif
          end
        end
        ST_ACCUM: begin
          state_r     <= sum_s;
          blk_cnt_r   <= blk_cnt_r + 16'd1;
          rsp_data_r  <= {16'd0, blk_cnt_r + 16'd1};
          rsp_err_r   <= 1'b0;
          rsp_valid_r <= 1'b1;
          fsm_r       <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            fsm_r       <= ST_IDLE;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          req_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
          fsm_r       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_cfu_sequencer.sv
// Self-checking bench: a behavioural SHA-256 core stub plus a word-level model of the chaining state.
// The watchdog scenario is compiled in only with SHA256_CFU_WATCHDOG_EN.
module tb_sha256_cfu_sequencer;

  localparam logic [2:0] C_INIT = 3'd0, C_WR = 3'd1, C_RUN = 3'd2, C_RD = 3'd3, C_STAT = 3'd4;
  localparam logic [31:0] IV [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] ABC [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = 3'd0;
  logic [2:0]   req_idx = 3'd0;
  logic [31:0]  req_data = 32'd0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [31:0]  rsp_data;
  logic         rsp_err;
  logic         core_en;
  logic         core_rst_n;
  logic [8:0]   core_base;
  logic [255:0] core_init;
  logic         core_rdy = 1'b1;
  logic [255:0] core_final = 256'd0;

  int errors = 0;
  int checks = 0;
  logic [31:0] ms [8];
  logic [15:0] mcnt;
  logic stub_drop = 1'b1;
  logic stub_hang = 1'b0;
  int   stub_lat = 4;
  int   stub_cnt = 0;
  int   en_hi = 0;
  int   rstn_low = 0;

  sha256_cfu_sequencer #(.TIMEOUT_CYCLES(512), .BASE_W(9)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_idx(req_idx), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .core_en(core_en), .core_rst_n(core_rst_n),
    .core_base(core_base), .core_init(core_init), .core_rdy(core_rdy), .core_final(core_final));

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] msg_word(input logic [8:0] base, input int i);
    if (base == 9'd0) return (i == 0) ? 32'h61626380 : ((i == 15) ? 32'h00000018 : 32'h0);
    else return ({23'd0, base} * 32'h9E3779B9) ^ (i * 32'h85EBCA6B);
  endfunction

  // Plain SHA-256 compression; returns the final working variables (no feed-forward)
  function automatic logic [255:0] compress(input logic [255:0] h, input logic [8:0] base);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = msg_word(base, i);
    for (int i = 16; i < 64; i++)
      w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
           + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
    for (int j = 0; j < 8; j++) v[j] = h[32*j +: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
         + K_TAB[i] + w[i];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) r[32*j +: 32] = v[j];
    return r;
  endfunction

  function automatic logic [255:0] model_packed();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = ms[j];
    return r;
  endfunction

  // Core stub: drops rdy after en, raises it after stub_lat cycles unless hung
  always @(posedge clk) begin
    if (core_rst_n === 1'b0) begin
      core_rdy <= 1'b1;
      stub_cnt <= 0;
    end else if (core_en === 1'b1 && stub_drop) begin
      core_rdy   <= 1'b0;
      stub_cnt   <= stub_lat;
      core_final <= compress(core_init, core_base);
    end else if (!core_rdy && !stub_hang) begin
      if (stub_cnt <= 1) core_rdy <= 1'b1;
      else stub_cnt <= stub_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (core_en === 1'b1) en_hi <= en_hi + 1;
    if (!rst && core_rst_n === 1'b0) rstn_low <= rstn_low + 1;
  end

  // hold < 0: rsp_ready high before the response; hold > 0: stall that many cycles first
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] idx, input logic [31:0] data,
                        input int hold, output logic [31:0] rd, output logic re);
    int n;
    logic stable;
    rd = 32'd0; re = 1'b0; n = 0;
    while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_timeout: req_ready=%b want 1", req_ready); end
    req_valid = 1'b1; req_op = op; req_idx = idx; req_data = data;
    rsp_ready = (hold < 0);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_drop: req_ready=%b want 0", req_ready); end
    n = 0;
    while (rsp_valid !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rsp_timeout: rsp_valid=%b want 1", rsp_valid); end
    rd = rsp_data; re = rsp_err;
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_data !== rd || rsp_err !== re || req_ready !== 1'b0) stable = 1'b0;
      end
      checks++;
      if (!stable) begin errors++; $display("FAIL rsp_hold: valid=%b data=%h err=%b ready=%b want 1 %h %b 0",
                                            rsp_valid, rsp_data, rsp_err, req_ready, rd, re); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_consume: rsp_valid=%b want 0", rsp_valid); end
  endtask

  task automatic check_all_words(input string tag);
    logic [31:0] rd;
    logic re;
    for (int i = 0; i < 8; i++) begin
      do_cmd(C_RD, 3'(i), $urandom, (i == 2) ? 5 : -1, rd, re);
      checks++;
      if (rd !== ms[i] || re !== 1'b0) begin
        errors++; $display("FAIL %s_word%0d: got %h err=%b want %h err=0", tag, i, rd, re, ms[i]);
      end
    end
  endtask

  task automatic model_run(input logic [8:0] base);
    logic [255:0] f;
    f = compress(model_packed(), base);
    for (int j = 0; j < 8; j++) ms[j] = ms[j] + f[32*j +: 32];
    mcnt = mcnt + 16'd1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic re;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_data !== 32'd0 ||
        core_en !== 1'b0 || core_rst_n !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: ready=%b valid=%b err=%b data=%h en=%b crst_n=%b want all 0",
                         req_ready, rsp_valid, rsp_err, rsp_data, core_en, core_rst_n);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || core_rst_n !== 1'b1) begin
      errors++; $display("FAIL reset_release: ready=%b crst_n=%b want 1 1", req_ready, core_rst_n);
    end
    for (int j = 0; j < 8; j++) ms[j] = IV[j];
    mcnt = 16'd0;
    check_all_words("reset_iv");
    do_cmd(C_STAT, 3'd0, 32'd0, -1, rd, re);
    checks++;
    if (rd !== 32'h0000_0002 || re !== 1'b0) begin
      errors++; $display("FAIL reset_status: got %h err=%b want 00000002 err=0", rd, re);
    end
  endtask

  task automatic test_wr_rd_init();
    logic [31:0] rd, d;
    logic re;
    logic [2:0] ix;
    do_cmd(C_WR, 3'd3, 32'hdeadbeef, 5, rd, re);
    ms[3] = 32'hdeadbeef;
    do_cmd(C_RD, 3'd3, 32'd0, 0, rd, re);
    checks++;
    if (rd !== 32'hdeadbeef || re !== 1'b0) begin errors++; $display("FAIL wr_rd3: got %h want deadbeef", rd); end
    for (int k = 0; k < 4; k++) begin
      ix = 3'($urandom_range(0, 7)); d = $urandom;
      do_cmd(C_WR, ix, d, -1, rd, re);
      ms[ix] = d;
      checks++;
      if (rd !== d || re !== 1'b0) begin errors++; $display("FAIL wr_echo: got %h err=%b want %h", rd, re, d); end
    end
    check_all_words("wr_rand");
    do_cmd(C_INIT, 3'd0, $urandom, 0, rd, re);
    checks++;
    if (rd !== 32'd0 || re !== 1'b0) begin errors++; $display("FAIL init_rsp: got %h err=%b want 0", rd, re); end
    for (int j = 0; j < 8; j++) ms[j] = IV[j];
    mcnt = 16'd0;
    do_cmd(C_RD, 3'd3, 32'd0, -1, rd, re);
    checks++;
    if (rd !== 32'ha54ff53a) begin errors++; $display("FAIL init_rd3: got %h want a54ff53a", rd); end
  endtask

  task automatic test_abc();
    logic [31:0] rd;
    logic re;
    int e0;
    do_cmd(C_INIT, 3'd0, 32'd0, -1, rd, re);
    for (int j = 0; j < 8; j++) ms[j] = IV[j];
    mcnt = 16'd0;
    e0 = en_hi;
    stub_lat = 6;
    do_cmd(C_RUN, 3'd0, 32'hFFFF_FE00, 5, rd, re);
    model_run(9'd0);
    checks++;
    if (rd !== 32'd1 || re !== 1'b0) begin errors++; $display("FAIL abc_run: got %h err=%b want 1 err=0", rd, re); end
    checks++;
    if (en_hi - e0 !== 1) begin errors++; $display("FAIL abc_en_pulse: got %0d cycles want 1", en_hi - e0); end
    for (int i = 0; i < 8; i++) begin
      do_cmd(C_RD, 3'(i), 32'd0, -1, rd, re);
      checks++;
      if (rd !== ABC[i]) begin errors++; $display("FAIL abc_digest%0d: got %h want %h", i, rd, ABC[i]); end
    end
  endtask

  task automatic test_random_runs();
    logic [31:0] rd, d;
    logic re;
    logic [8:0] b;
    logic [2:0] ix;
    int e0;
    for (int k = 0; k < 6; k++) begin
      ix = 3'($urandom_range(0, 7)); d = $urandom;
      do_cmd(C_WR, ix, d, -1, rd, re);
      ms[ix] = d;
      b = 9'($urandom_range(1, 511));
      stub_lat = $urandom_range(1, 12);
      e0 = en_hi;
      do_cmd(C_RUN, 3'($urandom), {$urandom_range(0, 8388607), b}, $urandom_range(0, 4) - 1, rd, re);
      model_run(b);
      checks++;
      if (rd !== {16'd0, mcnt} || re !== 1'b0 || en_hi - e0 !== 1) begin
        errors++; $display("FAIL run_rsp: got %h err=%b en=%0d want %h err=0 en=1", rd, re, en_hi - e0, mcnt);
      end
    end
    check_all_words("rand_runs");
    do_cmd(C_STAT, 3'd0, 32'd0, 2, rd, re);
    checks++;
    if (rd !== {mcnt, 16'h0002} || re !== 1'b0) begin
      errors++; $display("FAIL run_status: got %h want %h", rd, {mcnt, 16'h0002});
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic re;
    for (int op = 5; op < 8; op++) begin
      do_cmd(3'(op), 3'd1, $urandom, (op == 7) ? 5 : -1, rd, re);
      checks++;
      if (rd !== 32'd0 || re !== 1'b1) begin errors++; $display("FAIL bad_op%0d: got %h err=%b want 0 err=1", op, rd, re); end
    end
    stub_drop = 1'b0;
    do_cmd(C_RUN, 3'd0, 32'd5, -1, rd, re);
    stub_drop = 1'b1;
    checks++;
    if (re !== 1'b1) begin errors++; $display("FAIL no_busy_err: err=%b want 1", re); end
    check_all_words("after_err");
    do_cmd(C_STAT, 3'd0, 32'd0, -1, rd, re);
    checks++;
    if (rd[31:16] !== mcnt) begin errors++; $display("FAIL err_blk_cnt: got %h want %h", rd[31:16], mcnt); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] rd;
    logic re;
    stub_hang = 1'b1;
    while (req_ready !== 1'b1) @(negedge clk);
    req_valid = 1'b1; req_op = C_RUN; req_data = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (core_rst_n !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL midrun_rst: crst_n=%b valid=%b ready=%b want 0 0 0", core_rst_n, rsp_valid, req_ready);
    end
    stub_hang = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || core_rst_n !== 1'b1) begin
      errors++; $display("FAIL midrun_release: valid=%b crst_n=%b want 0 1", rsp_valid, core_rst_n);
    end
    for (int j = 0; j < 8; j++) ms[j] = IV[j];
    mcnt = 16'd0;
    do_cmd(C_RD, 3'd0, 32'd0, -1, rd, re);
    checks++;
    if (rd !== 32'h6a09e667) begin errors++; $display("FAIL midrun_rd0: got %h want 6a09e667", rd); end
    do_cmd(C_STAT, 3'd0, 32'd0, -1, rd, re);
    checks++;
    if (rd !== 32'h0000_0002) begin errors++; $display("FAIL midrun_status: got %h want 00000002", rd); end
  endtask

`ifdef SHA256_CFU_WATCHDOG_EN
  task automatic test_watchdog();
    logic [31:0] rd;
    logic re;
    int l0;
    stub_hang = 1'b1;
    l0 = rstn_low;
    do_cmd(C_RUN, 3'd0, 32'd3, -1, rd, re);
    stub_hang = 1'b0;
    checks++;
    if (rd !== 32'hDEAD0001 || re !== 1'b1 || rstn_low - l0 !== 1) begin
      errors++; $display("FAIL watchdog: got %h err=%b low=%0d want dead0001 err=1 low=1", rd, re, rstn_low - l0);
    end
    check_all_words("after_wdog");
  endtask
`endif

  initial begin
    test_reset();
    test_wr_rd_init();
    test_abc();
    test_random_runs();
    test_errors();
    test_reset_mid_run();
`ifdef SHA256_CFU_WATCHDOG_EN
    test_watchdog();
`endif
    test_random_runs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
